spi_sensor_slave: RTL and testbench



---
 rtl/spi_sensor_pkg.sv | 27 ++
 rtl/spi_sensor_regfile.sv | 79 +++++++
 rtl/spi_sensor_slave.sv | 122 ++++++++++++
 tb/tb_spi_sensor_slave.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sensor_pkg.sv
// rtl/spi_sensor_pkg.sv - shared phase type, byte constants and channel address decode
package spi_sensor_pkg;

  typedef enum logic {CMD, DATA} phase_t;

  localparam int CMD_RD_BIT = 7;
  localparam int BYTE_BITS  = 8;

  typedef struct packed {
    logic       hit;
    logic       hi;
    logic [5:0] idx;
  } ch_dec_t;

  // Channel k occupies base+2k (low byte) and base+2k+1 (high byte).
  function automatic ch_dec_t is_ch_addr(input logic [6:0] addr, input logic [6:0] base,
                                         input int num_ch);
    ch_dec_t d;
    int      off;
    off   = int'(addr) - int'(base);
    d.hit = (off >= 0) && (off < 2 * num_ch);
    d.hi  = off[0];
    d.idx = 6'(off >>> 1);
    return d;
  endfunction

endpackage

// File: rtl/spi_sensor_regfile.sv
// rtl/spi_sensor_regfile.sv - byte register file, write port, read mux and channel shadows
module spi_sensor_regfile
  import spi_sensor_pkg::*;
#(
  parameter int         NUM_REGS      = 128,
  parameter int         NUM_CH        = 4,
  parameter logic [6:0] CH_BASE       = 7'h22,
  parameter logic [6:0] WHO_AM_I_ADDR = 7'h0F,
  parameter logic [7:0] WHO_AM_I_VAL  = 8'h6A,
  parameter logic [6:0] EN_ADDR       = 7'h0D,
  parameter logic [7:0] EN_VAL        = 8'h02
) (
  input  logic                   SCLK,
  input  logic                   rst_n,
  input  logic [6:0]             addr,
  input  logic                   commit_en,
  input  logic [7:0]             commit_data,
  input  logic                   rd_stb,
  output logic [7:0]             rd_data,
  input  logic [16*NUM_CH-1:0]   ch_data,
  output logic                   enable,
  output logic                   wr_stb,
  output logic [6:0]             wr_addr,
  output logic [7:0]             wr_data
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [7:0] mem    [NUM_REGS];
  logic [7:0] shadow [NUM_CH];
  ch_dec_t    dec;
  logic       wr_ok;

  assign dec   = is_ch_addr(addr, CH_BASE, NUM_CH);
  assign wr_ok = commit_en && (addr != WHO_AM_I_ADDR) && !dec.hit && (int'(addr) < NUM_REGS);

  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_stb <= wr_ok;
      if (wr_ok) begin
        mem[addr[AW-1:0]] <= commit_data;
        wr_addr           <= addr;
        wr_data           <= commit_data;
      end
    end
  end

  // High byte is frozen on the same edge the low byte is handed to the shifter.
  always_ff @(negedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= '0;
    end else if (rd_stb && (addr != WHO_AM_I_ADDR) && dec.hit && !dec.hi) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (dec.idx == 6'(k)) shadow[k] <= ch_data[16*k+8 +: 8];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr == WHO_AM_I_ADDR) begin
      rd_data = WHO_AM_I_VAL;
    end else if (dec.hit) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (dec.idx == 6'(k)) rd_data = dec.hi ? shadow[k] : ch_data[16*k +: 8];
      end
    end else if (int'(addr) < NUM_REGS) begin
      rd_data = mem[addr[AW-1:0]];
    end
  end

  assign enable = (mem[EN_ADDR[AW-1:0]] == EN_VAL);

endmodule

// File: rtl/spi_sensor_slave.sv
// rtl/spi_sensor_slave.sv - SPI mode-3 sensor slave: shifters, phase FSM and MISO driver
module spi_sensor_slave
  import spi_sensor_pkg::*;
#(
  parameter int         NUM_REGS      = 128,
  parameter int         NUM_CH        = 4,
  parameter logic [6:0] CH_BASE       = 7'h22,
  parameter logic [6:0] WHO_AM_I_ADDR = 7'h0F,
  parameter logic [7:0] WHO_AM_I_VAL  = 8'h6A,
  parameter logic [6:0] EN_ADDR       = 7'h0D,
  parameter logic [7:0] EN_VAL        = 8'h02,
  parameter int         AUTO_INC      = 1,
  parameter logic [7:0] WR_RESP       = 8'hA5
) (
  input  logic                 SCLK,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  input  logic [16*NUM_CH-1:0] ch_data,
  output logic                 enable,
  output logic                 wr_stb,
  output logic [6:0]           wr_addr,
  output logic [7:0]           wr_data
);

  localparam logic [6:0] ADDR_MASK = 7'(NUM_REGS - 1);

  // Transaction state is held in reset whenever the slave is deselected.
  logic       txn_rst_n;
  phase_t     phase, phase_next;
  logic [2:0] bit_cnt;
  logic [6:0] rx;
  logic [7:0] rx_next;
  logic [7:0] tx;
  logic [6:0] addr, addr_next;
  logic       cmd_rd, cmd_rd_next;
  logic       byte_done;
  logic       commit_en;
  logic       rd_stb;
  logic [7:0] rd_data;

  assign txn_rst_n = rst_n & ~SS_n;
  assign rx_next   = {rx, MOSI};
  assign byte_done = (bit_cnt == 3'(BYTE_BITS - 1));

  always_ff @(posedge SCLK or negedge txn_rst_n) begin
    if (!txn_rst_n) begin
      phase   <= CMD;
      bit_cnt <= '0;
      rx      <= '0;
      addr    <= '0;
      cmd_rd  <= 1'b0;
    end else begin
      phase   <= phase_next;
      bit_cnt <= bit_cnt + 3'd1;
      rx      <= rx_next[6:0];
      addr    <= addr_next;
      cmd_rd  <= cmd_rd_next;
    end
  end

  always_comb begin
    phase_next  = phase;
    addr_next   = addr;
    cmd_rd_next = cmd_rd;
    commit_en   = 1'b0;
    if (byte_done) begin
      case (phase)
        CMD: begin
          phase_next  = DATA;
          cmd_rd_next = rx_next[CMD_RD_BIT];
          addr_next   = rx_next[CMD_RD_BIT-1:0];
        end
        DATA: begin
          commit_en = !cmd_rd;
          if (AUTO_INC != 0) addr_next = (addr + 7'd1) & ADDR_MASK;
        end
        default: phase_next = CMD;
      endcase
    end
  end

  // The first falling edge of each data byte loads the outgoing byte.
  assign rd_stb = (phase == DATA) && (bit_cnt == 3'd0) && cmd_rd;

  always_ff @(negedge SCLK or negedge txn_rst_n) begin
    if (!txn_rst_n) begin
      tx <= '0;
    end else if ((phase == DATA) && (bit_cnt == 3'd0)) begin
      tx <= cmd_rd ? rd_data : WR_RESP;
    end else begin
      tx <= {tx[6:0], 1'b0};
    end
  end

  assign MISO = SS_n ? 1'bz : tx[7];

  spi_sensor_regfile #(
    .NUM_REGS      (NUM_REGS),
    .NUM_CH        (NUM_CH),
    .CH_BASE       (CH_BASE),
    .WHO_AM_I_ADDR (WHO_AM_I_ADDR),
    .WHO_AM_I_VAL  (WHO_AM_I_VAL),
    .EN_ADDR       (EN_ADDR),
    .EN_VAL        (EN_VAL)
  ) u_regfile (
    .SCLK        (SCLK),
    .rst_n       (rst_n),
    .addr        (addr),
    .commit_en   (commit_en),
    .commit_data (rx_next),
    .rd_stb      (rd_stb),
    .rd_data     (rd_data),
    .ch_data     (ch_data),
    .enable      (enable),
    .wr_stb      (wr_stb),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

endmodule

// File: tb/tb_spi_sensor_slave.sv
// tb/tb_spi_sensor_slave.sv - self-checking bench for spi_sensor_slave (auto-increment and fixed-address parts)
module tb_spi_sensor_slave;

  logic        SCLK    = 1'b1;
  logic        rst_n   = 1'b1;
  logic        SS_n    = 1'b0;
  logic        MOSI    = 1'b0;
  logic [63:0] ch_data = 64'h0004_0003_0002_1234;

  wire       miso_a, miso_b;
  wire [1:0] en, stb;
  wire [6:0] waddr_a, waddr_b;
  wire [7:0] wdata_a, wdata_b;

  int checks   = 0;
  int failures = 0;

  // Reference model: index 0 mirrors the auto-increment part, index 1 the fixed-address part.
  logic [7:0] m_mem    [2][128];
  logic [7:0] m_shadow [2][4];
  logic [6:0] m_addr   [2];
  logic       m_rd;

  typedef struct packed {
    int          n;
    logic [39:0] bytes;
    int          abort_bits;
    logic [7:0]  abort_byte;
    int          chg_at;
    logic [63:0] chg_val;
    logic [7:0]  exp_last;
    logic        exp_en;
  } vec_t;

  vec_t tbl [12];

  spi_sensor_slave dut_inc (
    .SCLK(SCLK), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso_a), .ch_data(ch_data),
    .enable(en[0]), .wr_stb(stb[0]), .wr_addr(waddr_a), .wr_data(wdata_a)
  );

  spi_sensor_slave #(.AUTO_INC(0)) dut_fix (
    .SCLK(SCLK), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso_b), .ch_data(ch_data),
    .enable(en[1]), .wr_stb(stb[1]), .wr_addr(waddr_b), .wr_data(wdata_b)
  );

  function automatic vec_t mk(input int n, input logic [39:0] b, input int ab, input logic [7:0] abb,
                              input int ca, input logic [63:0] cv, input logic [7:0] el, input logic ee);
    vec_t v;
    v.n = n; v.bytes = b; v.abort_bits = ab; v.abort_byte = abb;
    v.chg_at = ca; v.chg_val = cv; v.exp_last = el; v.exp_en = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit is_ch(input logic [6:0] a);
    return (a >= 7'h22) && (a < 7'h2A);
  endfunction

  function automatic logic [7:0] m_read(input bit d, input logic [6:0] a);
    logic [6:0] off;
    logic [1:0] k;
    if (a == 7'h0F) return 8'h6A;
    if (is_ch(a)) begin
      off = a - 7'h22;
      k   = off[2:1];
      if (!off[0]) begin
        m_shadow[d][k] = ch_data[16*k+8 +: 8];
        return ch_data[16*k +: 8];
      end
      return m_shadow[d][k];
    end
    return m_mem[d][a];
  endfunction

  function automatic bit m_write(input bit d, input logic [6:0] a, input logic [7:0] v);
    if (a == 7'h0F || is_ch(a)) return 1'b0;
    m_mem[d][a] = v;
    return 1'b1;
  endfunction

  function automatic logic m_en(input bit d);
    return m_mem[d][7'h0D] == 8'h02;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 128; a++) m_mem[d][a] = 8'h00;
      for (int k = 0; k < 4; k++) m_shadow[d][k] = 8'h00;
    end
    m_rd = 1'b0;
  endtask

  // Clocks nb bits MSB first; returns MISO sampled just before each rise. Ends 1 unit after the last rise.
  task automatic send_bits(input logic [7:0] v, input int nb, output logic [7:0] ma, output logic [7:0] mb);
    logic [7:0] sh;
    sh = v; ma = '0; mb = '0;
    for (int k = 0; k < nb; k++) begin
      SCLK = 1'b0; MOSI = sh[7]; sh = sh << 1;
      #4; ma = {ma[6:0], miso_a}; mb = {mb[6:0], miso_b};
      #1; SCLK = 1'b1;
      #1;
      if (k != nb - 1) #4;
    end
  endtask

  task automatic run_xfer(input logic [39:0] bytes, input int n, input int abort_bits,
                          input logic [7:0] abort_byte, input int chg_at, input logic [63:0] chg_val,
                          output logic [7:0] last_a);
    logic [7:0]  b, ga, gb, ea, eb, dummy;
    logic [39:0] sh;
    bit          sa, sb;
    sh = bytes; last_a = '0;
    SS_n = 1'b0; #5;
    for (int i = 0; i < n; i++) begin
      b = sh[39:32]; sh = sh << 8;
      if (i == chg_at) ch_data = chg_val;
      if (i == 0) begin
        ea = 8'h00; eb = 8'h00;
      end else if (m_rd) begin
        ea = m_read(1'b0, m_addr[0]); eb = m_read(1'b1, m_addr[1]);
      end else begin
        ea = 8'hA5; eb = 8'hA5;
      end
      send_bits(b, 8, ga, gb);
      chk($sformatf("miso_inc byte%0d", i), 32'(ga), 32'(ea));
      chk($sformatf("miso_fix byte%0d", i), 32'(gb), 32'(eb));
      last_a = ga;
      if (i == 0) begin
        m_rd = b[7]; m_addr[0] = b[6:0]; m_addr[1] = b[6:0];
      end else begin
        if (!m_rd) begin
          sa = m_write(1'b0, m_addr[0], b);
          sb = m_write(1'b1, m_addr[1], b);
          chk("wr_stb_inc", 32'(stb[0]), 32'(sa));
          chk("wr_stb_fix", 32'(stb[1]), 32'(sb));
          if (sa) begin
            chk("wr_addr_inc", 32'(waddr_a), 32'(m_addr[0]));
            chk("wr_data_inc", 32'(wdata_a), 32'(b));
          end
          if (sb) begin
            chk("wr_addr_fix", 32'(waddr_b), 32'(m_addr[1]));
            chk("wr_data_fix", 32'(wdata_b), 32'(b));
          end
        end
        m_addr[0] = m_addr[0] + 7'd1;
      end
      #4;
    end
    if (abort_bits > 0) begin
      if (n > 1 && m_rd) begin
        dummy = m_read(1'b0, m_addr[0]);
        dummy = m_read(1'b1, m_addr[1]);
      end
      send_bits(abort_byte, abort_bits, ga, gb);
      chk("abort_no_stb_inc", 32'(stb[0]), 32'd0);
      chk("abort_no_stb_fix", 32'(stb[1]), 32'd0);
      #4;
    end
    #2; SS_n = 1'b1; #10;
  endtask

  initial begin
    logic [7:0] last, ga, gb;
    m_reset();
    m_addr[0] = '0; m_addr[1] = '0;

    tbl[0]  = mk(2, 40'h8F_00_00_00_00, 0, 8'h00, -1, 64'h0, 8'h6A, 1'b0);
    tbl[1]  = mk(2, 40'h0F_55_00_00_00, 0, 8'h00, -1, 64'h0, 8'hA5, 1'b0);
    tbl[2]  = mk(2, 40'h8F_00_00_00_00, 0, 8'h00, -1, 64'h0, 8'h6A, 1'b0);
    tbl[3]  = mk(2, 40'h0D_02_00_00_00, 0, 8'h00, -1, 64'h0, 8'hA5, 1'b1);
    tbl[4]  = mk(2, 40'h0D_03_00_00_00, 0, 8'h00, -1, 64'h0, 8'hA5, 1'b0);
    tbl[5]  = mk(3, 40'hA2_00_00_00_00, 0, 8'h00,  2, 64'h0004_0003_0002_ABCD, 8'h12, 1'b0);
    tbl[6]  = mk(4, 40'h7E_11_22_33_00, 0, 8'h00, -1, 64'h0, 8'hA5, 1'b0);
    tbl[7]  = mk(4, 40'hFE_00_00_00_00, 0, 8'h00, -1, 64'h0, 8'h33, 1'b0);
    tbl[8]  = mk(2, 40'h10_5C_00_00_00, 0, 8'h00, -1, 64'h0, 8'hA5, 1'b0);
    tbl[9]  = mk(1, 40'h10_00_00_00_00, 4, 8'h77, -1, 64'h0, 8'h00, 1'b0);
    tbl[10] = mk(2, 40'h90_00_00_00_00, 0, 8'h00, -1, 64'h0, 8'h5C, 1'b0);
    tbl[11] = mk(2, 40'h0D_02_00_00_00, 0, 8'h00, -1, 64'h0, 8'hA5, 1'b1);

    #1 rst_n = 1'b0;
    #10;
    chk("reset_enable_inc", 32'(en[0]), 32'd0);
    chk("reset_enable_fix", 32'(en[1]), 32'd0);
    chk("reset_wr_stb", 32'(stb), 32'd0);
    chk("reset_wr_addr", 32'(waddr_a), 32'd0);
    chk("reset_wr_data", 32'(wdata_a), 32'd0);
    chk("reset_miso", 32'(miso_a), 32'd0);
    SS_n = 1'b1; #5;
    rst_n = 1'b1; #10;

    for (int i = 0; i < 12; i++) begin
      run_xfer(tbl[i].bytes, tbl[i].n, tbl[i].abort_bits, tbl[i].abort_byte,
               tbl[i].chg_at, tbl[i].chg_val, last);
      chk($sformatf("tbl%0d_last_miso", i), 32'(last), 32'(tbl[i].exp_last));
      chk($sformatf("tbl%0d_enable", i), 32'(en[0]), 32'(tbl[i].exp_en));
      chk($sformatf("tbl%0d_enable_fix", i), 32'(en[1]), 32'(m_en(1'b1)));
    end

    // Reset pulse in the middle of a WHO_AM_I data byte (0x6A: second bit is 1).
    SS_n = 1'b0; #5;
    send_bits(8'h8F, 8, ga, gb); #4;
    send_bits(8'h00, 2, ga, gb);
    chk("pre_reset_bits", 32'(ga[1:0]), 32'd1);
    rst_n = 1'b0; #2;
    m_reset();
    chk("mid_reset_miso_inc", 32'(miso_a), 32'd0);
    chk("mid_reset_miso_fix", 32'(miso_b), 32'd0);
    chk("mid_reset_enable", 32'(en), 32'd0);
    #3 rst_n = 1'b1; #5 SS_n = 1'b1; #10;
    run_xfer(40'h8D_00_00_00_00, 2, 0, 8'h00, -1, 64'h0, last);
    chk("post_reset_en_read", 32'(last), 32'd0);

    for (int t = 0; t < 40; t++) begin
      logic [39:0] bb;
      logic [6:0]  a;
      int          n, ca;
      n = $urandom_range(2, 5);
      case ($urandom_range(0, 5))
        0:       a = 7'h0D;
        1:       a = 7'h0F;
        2:       a = 7'(7'h22 + 7'($urandom_range(0, 7)));
        3:       a = 7'h7E;
        default: a = 7'($urandom);
      endcase
      bb = {1'($urandom), a, 32'($urandom)};
      if ($urandom_range(0, 3) == 0) bb[31:24] = 8'h02;
      ca = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
      run_xfer(bb, n, 0, 8'h00, ca, {$urandom, $urandom}, last);
      chk("rand_enable_inc", 32'(en[0]), 32'(m_en(1'b0)));
      chk("rand_enable_fix", 32'(en[1]), 32'(m_en(1'b1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
